// File: rtl/or_trigger_unit_if.sv
// Channel, configuration and trigger-output bundle for or_trigger_unit.
// master drives the front-end/config side; slave is the trigger unit.
interface or_trigger_unit_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    localparam int TW = $clog2(N_CH + 1);

    logic [N_CH-1:0]  ch_in;
    logic [N_CH-1:0]  mask;
    logic [1:0]       mode;
    logic [TW-1:0]    thr;
    logic             clr_count;
    logic             trig_out;
    logic             busy;
    logic [N_CH-1:0]  hit_latch;
    logic [CNT_W-1:0] trig_count;

    modport master (
        output ch_in, mask, mode, thr, clr_count,
        input  trig_out, busy, hit_latch, trig_count
    );

    modport slave (
        input  ch_in, mask, mode, thr, clr_count,
        output trig_out, busy, hit_latch, trig_count
    );
endinterface

// File: rtl/or_trigger_unit.sv
// N-channel OR/AND/majority trigger with fixed pulse, dead time and hit latch.
// Optional trigger counter enabled by defining COINC_COUNTER_EN.
module or_trigger_unit #(
    parameter int N_CH  = 4,
    parameter int HOLD  = 4,
    parameter int DEAD  = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    or_trigger_unit_if.slave bus
);
    localparam int TW   = $clog2(N_CH + 1);
    localparam int CMAX = (HOLD > DEAD) ? HOLD : DEAD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_DEAD
    } state_t;

    logic [N_CH-1:0] s1_q;
    logic [N_CH-1:0] s2_q;
    logic [N_CH-1:0] m;
    logic [TW-1:0]   pop;
    logic            cond_d;
    logic            cond_prev_q;
    logic            trig_ev;
    logic            fire;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            trig_q;
    logic            busy_q;
    logic [N_CH-1:0] hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            cond_prev_q <= 1'b0;
        end else begin
            s1_q        <= bus.ch_in;
            s2_q        <= s1_q;
            cond_prev_q <= cond_d;
        end
    end

    assign m = s2_q & bus.mask;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + TW'(m[i]);
        end
    end

    // An empty mask disables triggering regardless of mode.
    always_comb begin
        cond_d = 1'b0;
        unique case (bus.mode)
            2'b00:   cond_d = |m;
            2'b01:   cond_d = (m == bus.mask);
            2'b10:   cond_d = (bus.thr != '0) && (pop >= bus.thr);
            default: cond_d = 1'b0;
        endcase
        if (bus.mask == '0) begin
            cond_d = 1'b0;
        end
    end

    assign trig_ev = cond_d & ~cond_prev_q;
    assign fire    = (state_q == S_IDLE) && trig_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trig_ev) begin
                        state_q <= S_FIRE;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        hit_q   <= m;
                        cnt_q   <= CW'(HOLD - 1);
                    end
                end
                S_FIRE: begin
                    if (cnt_q == '0) begin
                        trig_q <= 1'b0;
                        if (DEAD > 0) begin
                            state_q <= S_DEAD;
                            cnt_q   <= CW'(DEAD - 1);
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DEAD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig_out  = trig_q;
    assign bus.busy      = busy_q;
    assign bus.hit_latch = hit_q;

`ifdef COINC_COUNTER_EN
    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_comb begin
        tcnt_d = tcnt_q;
        if (bus.clr_count) begin
            tcnt_d = '0;
        end else if (fire && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign bus.trig_count = tcnt_q;
`else
    logic unused_clr;
    logic unused_fire;

    assign unused_clr     = bus.clr_count;
    assign unused_fire    = fire;
    assign bus.trig_count = '0;
`endif

endmodule

// File: tb/tb_or_trigger_unit.sv
// Scoreboard bench for or_trigger_unit: directed scenarios plus random traffic.
// Reference model tracks time since the last trigger instead of FSM states.
module tb_or_trigger_unit;
    localparam int N_CH  = 4;
    localparam int HOLD  = 4;
    localparam int DEAD  = 8;
    localparam int CNT_W = 3;
    localparam int TW    = $clog2(N_CH + 1);
    localparam int CMAXV = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             trig;
        logic             busy;
        logic [N_CH-1:0]  hit;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    or_trigger_unit_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    or_trigger_unit #(
        .N_CH (N_CH),
        .HOLD (HOLD),
        .DEAD (DEAD),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    logic [N_CH-1:0] mask_v = '0;
    logic [1:0]      mode_v = 2'b00;
    logic [TW-1:0]   thr_v  = '0;

    // reference model state
    int              cyc  = 0;
    int              last = -1000;
    int              cntm = 0;
    logic [N_CH-1:0] s1m  = '0;
    logic [N_CH-1:0] s2m  = '0;
    logic [N_CH-1:0] hitm = '0;
    logic            cpm  = 1'b0;

    function automatic logic cond_of(input logic [N_CH-1:0] mm,
                                     input logic [N_CH-1:0] mk,
                                     input logic [1:0] md,
                                     input int th);
        int pc;
        pc = $countones(mm);
        if (mk == '0) return 1'b0;
        case (md)
            2'b00:   return pc > 0;
            2'b01:   return mm == mk;
            2'b10:   return (th != 0) && (pc >= th);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic [N_CH-1:0] ch,
                        input logic r = 1'b0,
                        input logic clr = 1'b0);
        logic [N_CH-1:0] mm;
        logic            c;
        exp_t            e;
        @(negedge clk);
        bus.ch_in     = ch;
        bus.mask      = mask_v;
        bus.mode      = mode_v;
        bus.thr       = thr_v;
        bus.clr_count = clr;
        rst           = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            s1m  = '0;
            s2m  = '0;
            cpm  = 1'b0;
            last = -1000;
            hitm = '0;
            cntm = 0;
        end else begin
            mm = s2m & mask_v;
            c  = cond_of(mm, mask_v, mode_v, int'(thr_v));
            if (c && !cpm && (cyc - last > HOLD + DEAD)) begin
                last = cyc;
                hitm = mm;
                if (cntm < CMAXV) cntm++;
            end
            if (clr) cntm = 0;
            cpm = c;
            s2m = s1m;
            s1m = ch;
        end
        e.trig = (cyc - last) < HOLD;
        e.busy = (cyc - last) < HOLD + DEAD;
        e.hit  = hitm;
`ifdef COINC_COUNTER_EN
        e.cnt  = CNT_W'(cntm);
`else
        e.cnt  = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic hold_ch(input logic [N_CH-1:0] ch, input int n);
        for (int i = 0; i < n; i++) step(ch);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {bus.trig_out, bus.busy, bus.hit_latch, bus.trig_count};
                nvec++;
                if (a !== e) begin
                    nerr++;
                    $display("FAIL outputs @%0t: got trig=%b busy=%b hit=%b cnt=%0d, want trig=%b busy=%b hit=%b cnt=%0d",
                             $time, a.trig, a.busy, a.hit, a.cnt,
                             e.trig, e.busy, e.hit, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        logic [N_CH-1:0] ch;
        bus.ch_in     = '0;
        bus.mask      = '0;
        bus.mode      = 2'b00;
        bus.thr       = '0;
        bus.clr_count = 1'b0;
        rst           = 1'b1;
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        idle(3);

        // OR mode, masked channel triggers, unmasked one does not
        mode_v = 2'b00; mask_v = 4'b0101;
        hold_ch(4'b0100, 10); idle(20);
        hold_ch(4'b0010, 5);  idle(15);

        // AND mode, staggered channels then empty mask
        mode_v = 2'b01; mask_v = 4'b0011;
        hold_ch(4'b0001, 5); hold_ch(4'b0011, 8); idle(20);
        mask_v = 4'b0000;
        hold_ch(4'b1111, 5); idle(10);

        // majority 3-of-4, then zero threshold
        mode_v = 2'b10; mask_v = 4'b1111; thr_v = 3;
        hold_ch(4'b0011, 5); hold_ch(4'b0111, 5); idle(20);
        thr_v = 0;
        hold_ch(4'b1111, 5); idle(10);

        // retrigger suppression and long level
        mode_v = 2'b00; mask_v = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(4'b0001); idle(5);
        end
        idle(15);
        hold_ch(4'b0001, 50); idle(20);

        // reset during the pulse with the input held high
        hold_ch(4'b0001, 4);
        step(4'b0001, 1'b1);
        hold_ch(4'b0001, 20); idle(20);

        // counter: triggers, clear coincident with a trigger, saturation
        for (int k = 0; k < 5; k++) begin
            step(4'b0010); idle(15);
        end
        step(4'b0010); step('0); step('0, 1'b0, 1'b1); idle(15);
        for (int k = 0; k < 10; k++) begin
            step(4'b1000); idle(15);
        end

        // mode change that makes the condition rise while idle
        mode_v = 2'b11; hold_ch(4'b0001, 5);
        mode_v = 2'b00; hold_ch(4'b0001, 5); idle(20);

        // random traffic
        ch = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) begin
                mode_v = 2'($urandom_range(3));
                mask_v = N_CH'($urandom);
                thr_v  = TW'($urandom_range(5));
            end
            for (int b = 0; b < N_CH; b++)
                if ($urandom_range(7) == 0) ch[b] = ~ch[b];
            step(ch, $urandom_range(299) == 0, $urandom_range(59) == 0);
        end
        idle(5);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            nerr++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/or_trigger_unit.md
Name: or_trigger_unit

Overview:
- Parametrised N-channel coincidence/trigger unit; successor of the plain 2-input OR gate.
- Synchronises asynchronous discriminator inputs, masks them, and evaluates OR / AND / majority logic.
- Emits a fixed-width trigger pulse, then enforces a dead time; latches which channels caused the trigger.
- Sits between front-end digital inputs and the acquisition/readout logic.

Parameters:
- N_CH, 4, number of input channels (2..16).
- HOLD, 4, trig_out pulse width in clk cycles (>=1).
- DEAD, 8, dead-time cycles after pulse, busy held (>=0; 0 = no dead state).
- CNT_W, 16, width of trigger counter.
- TW = $clog2(N_CH+1) (localparam), threshold width.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; one clock, synchronous, active-high.
- ch_in, in, N_CH, asynchronous channel inputs.
- mask, in, N_CH, channel enable (1 = channel participates); synchronous to clk.
- mode, in, 2, 00 OR, 01 AND, 10 majority, 11 disabled.
- thr, in, TW, majority threshold (mode 10 only).
- clr_count, in, 1, synchronous clear of trig_count.
- trig_out, out, 1, trigger pulse (registered).
- busy, out, 1, high in FIRE and DEAD states (registered).
- hit_latch, out, N_CH, masked channel pattern captured at trigger.
- trig_count, out, CNT_W, number of triggers issued.

Behaviour:
- Reset: all flops cleared; state IDLE; trig_out=0, busy=0, hit_latch=0, trig_count=0; sync stages and cond_prev=0.
- Sync: per channel 2-flop chain s1->s2; m = s2 & mask.
- cond (combinational from m, mode, thr): OR = |m; AND = (mask!=0) && (m==mask); majority = (thr!=0) && popcount(m)>=thr; mode 11 -> 0. mask==0 -> cond=0 in every mode.
- cond_prev <= cond every cycle in all states. Trigger event = cond & ~cond_prev (rising of condition only). Long levels fire once.
- FSM:
  - IDLE: on event -> FIRE; trig_out<=1, busy<=1, hit_latch<=m, counter reset to HOLD-1.
  - FIRE: count down; at 0 -> DEAD (if DEAD>0, counter=DEAD-1, trig_out<=0) else IDLE (trig_out<=0, busy<=0).
  - DEAD: count down; at 0 -> IDLE, busy<=0.
- Events in FIRE/DEAD are ignored. A condition that rises during FIRE/DEAD and stays high does not fire on return to IDLE; it must fall and re-rise.
- Latency: ch_in sampled high at edge E -> s2=1 after E+1 -> trig_out=1 after E+2. trig_out high exactly HOLD cycles; busy high HOLD+DEAD cycles. Minimum spacing between trig_out rising edges = HOLD+DEAD+1 cycles.
- hit_latch is stable from the trigger until the next trigger.
- mode/mask/thr changes take effect on the next cond evaluation. A change that makes cond rise while in IDLE is a valid trigger.
- Reset mid-FIRE/DEAD: outputs 0 on the next edge, pulse truncated. An input held high through reset fires at the 3rd edge after rst deasserts.

Optional Feature:
- COINC_COUNTER_EN defined:
  - trig_count increments by 1 on each IDLE->FIRE transition.
  - Saturates at 2^CNT_W-1.
  - clr_count clears to 0 on the next edge; clear wins over a simultaneous increment.
- COINC_COUNTER_EN undefined: trig_count tied to 0, clr_count ignored, no counter flops.

Test Plan:
- N_CH=4, mode=00, mask=4'b0101: pulse ch_in[2] high for 10 cycles -> trig_out high 4 cycles starting 2 edges after sampling, busy 12 cycles, hit_latch=4'b0100; ch_in[1] pulse -> no trigger.
- mode=01, mask=4'b0011: ch0 high, then ch1 high 5 cycles later -> single trigger when ch1 reaches s2, hit_latch=4'b0011; mask=0 with all high -> no trigger.
- mode=10, thr=3, mask=4'hF: 2 channels high -> none; third rises -> trigger; thr=0 with all high -> none.
- Retrigger: OR mode, ch0 pulses every 6 cycles with HOLD=4, DEAD=8 -> triggers only every 13+ cycles; level held high 50 cycles -> exactly one trigger.
- Assert rst during FIRE (cycle 2 of pulse) -> trig_out, busy, hit_latch=0 next edge; ch0 held high -> new trigger 3 edges after rst release.
- COINC_COUNTER_EN: 5 triggers -> trig_count=5; clr_count coincident with a 6th trigger -> 0; CNT_W=2 with 5 triggers -> saturates at 3.
